// File: rtl/flash_arb_pkg.sv
// Shared definitions for the two-requester flash command arbiter:
// op encodings, FSM states, field widths and length limits.
package flash_arb_pkg;

  localparam int ADDR_W       = 25;
  localparam int PROG_MAX_LEN = 1023;
  localparam int READ_MAX_LEN = 131071;
  localparam int LEN_W        = $clog2(READ_MAX_LEN + 1);

  typedef enum logic [1:0] {
    OP_ERASE   = 2'b00,
    OP_PROG    = 2'b01,
    OP_READ    = 2'b10,
    OP_ILLEGAL = 2'b11
  } flash_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } arb_state_e;

  // Read length can never exceed READ_MAX_LEN because LEN_W is sized from it.
  function automatic logic cmd_rejected(input flash_op_e op_v, input logic [LEN_W-1:0] len_v);
    logic rej;
    rej = 1'b0;
    case (op_v)
      OP_ILLEGAL: rej = 1'b1;
      OP_PROG:    rej = (len_v == '0) || (len_v > LEN_W'(PROG_MAX_LEN));
      OP_READ:    rej = (len_v == '0);
      default:    rej = 1'b0;
    endcase
    return rej;
  endfunction

endpackage

// File: rtl/flash_rr_pick.sv
// Two-way round-robin picker; on a tie the requester not granted last wins.
// The last-grant pointer moves only when the owner consumes the pick.
module flash_rr_pick
  import flash_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic last_q, last_d;

  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'b0;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_q;
      default: winner_o = 1'b0;
    endcase
    last_d = advance_i ? winner_o : last_q;
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/flash_cmd_arbiter.sv
// Arbitrates erase/program/read commands from two requesters onto one flash
// engine: IDLE picks and strobes, WAIT waits for the matching done or timeout.
module flash_cmd_arbiter
  import flash_arb_pkg::*;
#(
  parameter int TIMEOUT = 50_000_000,
  parameter int TO_W    = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [3:0]        op,
  input  logic [49:0]       addr,
  input  logic [33:0]       len,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic              erase_en,
  output logic              prog_en,
  output logic              read_en,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              erase_done,
  input  logic              prog_done,
  input  logic              read_done,
  output logic              busy,
  output logic              grant_id,
  output arb_state_e        dbg_state
);

  // Handshake: req[i] is held until ack[i]; ack/done/err and the engine
  // strobes are single-cycle registered pulses, never back-pressured.

  arb_state_e        state_q, state_d;
  flash_op_e         op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              gid_q, gid_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [1:0]        ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic              erase_q, erase_d, prog_q, prog_d, read_q, read_d;

  logic              pick_valid, pick_winner, advance;
  flash_op_e         sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [1:0]        win_mask, gid_mask;
  logic              done_match;

  flash_rr_pick u_pick (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .advance_i (advance),
    .valid_o   (pick_valid),
    .winner_o  (pick_winner)
  );

  assign sel_op   = pick_winner ? flash_op_e'(op[3:2]) : flash_op_e'(op[1:0]);
  assign sel_addr = pick_winner ? addr[49:25] : addr[24:0];
  assign sel_len  = pick_winner ? len[33:17] : len[16:0];
  assign win_mask = pick_winner ? 2'b10 : 2'b01;
  assign gid_mask = gid_q ? 2'b10 : 2'b01;

  assign done_match = ((op_q == OP_ERASE) && erase_done) ||
                      ((op_q == OP_PROG)  && prog_done)  ||
                      ((op_q == OP_READ)  && read_done);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    len_d   = len_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    ack_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = 2'b00;
    erase_d = 1'b0;
    prog_d  = 1'b0;
    read_d  = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          advance = 1'b1;
          gid_d   = pick_winner;
          op_d    = sel_op;
          addr_d  = sel_addr;
          len_d   = sel_len;
          ack_d   = win_mask;
          if (cmd_rejected(sel_op, sel_len)) begin
            err_d = win_mask;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            case (sel_op)
              OP_ERASE: erase_d = 1'b1;
              OP_PROG:  prog_d  = 1'b1;
              default:  read_d  = 1'b1;
            endcase
          end
        end
      end
      ST_WAIT: begin
        // A matching done in the last counted cycle beats the timeout.
        if (done_match) begin
          state_d = ST_DONE;
          done_d  = gid_mask;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = gid_mask;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ERASE;
      addr_q  <= '0;
      len_q   <= '0;
      gid_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      erase_q <= 1'b0;
      prog_q  <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      erase_q <= erase_d;
      prog_q  <= prog_d;
      read_q  <= read_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign erase_en  = erase_q;
  assign prog_en   = prog_q;
  assign read_en   = read_q;
  assign cmd_addr  = addr_q;
  assign cmd_len   = len_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = gid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flash_cmd_arbiter.sv
// Self-checking bench for flash_cmd_arbiter: directed commands push expected
// output events to a queue, a negedge monitor pops and compares them.
module tb_flash_cmd_arbiter;
  import flash_arb_pkg::*;

  localparam int TIMEOUT = 100;
  localparam int EW      = 52;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  op;
  logic [49:0] addr;
  logic [33:0] len;
  logic [1:0]  ack, done, err;
  logic        erase_en, prog_en, read_en;
  logic [24:0] cmd_addr;
  logic [16:0] cmd_len;
  logic        erase_done, prog_done, read_done;
  logic        busy, grant_id;
  arb_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_strobe_cyc = -1;
  int strobe_gap_min  = 1000;
  int strobe_cyc = -1;
  int done_cyc   = -1;
  int err_cyc    = -1;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs;

  flash_cmd_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(26)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .len(len),
    .ack(ack), .done(done), .err(err),
    .erase_en(erase_en), .prog_en(prog_en), .read_en(read_en),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .erase_done(erase_done), .prog_done(prog_done), .read_done(read_done),
    .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [1:0] a, input logic [1:0] d,
                                       input logic [1:0] e, input logic [2:0] s,
                                       input logic g, input logic [24:0] ad,
                                       input logic [16:0] ln);
    return {a, d, e, s, g, ad, ln};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && ((ack | done | err) != 2'b00 || erase_en || prog_en || read_en)) begin
      obs = {ack, done, err, erase_en, prog_en, read_en, grant_id, cmd_addr, cmd_len};
      if (exp_q.size() == 0) check("unexpected_event", obs, '0);
      else                   check("event", obs, exp_q.pop_front());
      if (erase_en || prog_en || read_en) begin
        if (last_strobe_cyc >= 0 && (cyc - last_strobe_cyc) < strobe_gap_min)
          strobe_gap_min = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
        strobe_cyc      = cyc;
      end
      if (done != 2'b00) done_cyc = cyc;
      if (err  != 2'b00) err_cyc  = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; req = 2'b00;
    erase_done = 1'b0; prog_done = 1'b0; read_done = 1'b0;
    #1;
    check("reset_outputs",
          {ack, done, err, erase_en, prog_en, read_en, busy, grant_id, cmd_addr, cmd_len}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    last_strobe_cyc = -1;
    strobe_gap_min  = 1000;
  endtask

  task automatic set_fields(input int id, input logic [1:0] o, input logic [24:0] a,
                            input logic [16:0] l);
    if (id == 0) begin op[1:0] = o; addr[24:0]  = a; len[16:0]  = l; end
    else         begin op[3:2] = o; addr[49:25] = a; len[33:17] = l; end
  endtask

  task automatic wait_ack(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (ack[id]) ok = 1'b1;
    end
  endtask

  task automatic pulse_engine(input logic [1:0] o);
    erase_done = (o == 2'b00);
    prog_done  = (o == 2'b01);
    read_done  = (o == 2'b10);
    @(posedge clk);
    #1;
    erase_done = 1'b0; prog_done = 1'b0; read_done = 1'b0;
  endtask

  // One command from a single requester; accepted commands get their done
  // after resp_delay cycles counted from the strobe.
  task automatic run_cmd(input int id, input logic [1:0] o, input logic [24:0] a,
                         input logic [16:0] l, input int resp_delay);
    logic [1:0] m;
    logic [2:0] s;
    bit rej, ok;
    int rd_cyc;
    m   = (id == 1) ? 2'b10 : 2'b01;
    rej = (o == 2'b11) || (o != 2'b00 && l == 17'd0) || (o == 2'b01 && l > 17'd1023);
    s   = rej ? 3'b000 : (o == 2'b00) ? 3'b100 : (o == 2'b01) ? 3'b010 : 3'b001;
    set_fields(id, o, a, l);
    exp_q.push_back(ev(m, 2'b00, rej ? m : 2'b00, s, id[0], a, l));
    req = req | m;
    wait_ack(id, ok);
    req = req & ~m;
    check("ack_seen", ok, 1);
    check("grant_id", grant_id, id[0]);
    if (rej) begin
      check("rej_no_strobe", {erase_en, prog_en, read_en}, 3'b000);
      @(posedge clk);
      #1;
      check("rej_busy_low", busy, 0);
    end else begin
      check("busy_in_wait", busy, 1);
      repeat (resp_delay) @(posedge clk);
      #1;
      check("addr_stable", cmd_addr, a);
      rd_cyc   = cyc;
      done_cyc = -100;
      exp_q.push_back(ev(2'b00, m, 2'b00, 3'b000, id[0], a, l));
      pulse_engine(o);
      @(negedge clk);
      #1;
      check("done_latency", done_cyc - rd_cyc, 1);
      @(posedge clk);
      #1;
      check("idle_after_done", busy, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    logic w, model_last;
    logic [1:0] m;
    logic [24:0] a;
    logic [16:0] l;

    op = '0; addr = '0; len = '0;
    do_reset();

    // Single read, done 20 cycles after the strobe.
    set_fields(1, 2'b01, 25'h1555555, 17'd3);
    run_cmd(0, 2'b10, 25'h000100, 17'd256, 20);

    // Withdrawn request: raised and dropped between edges.
    set_fields(0, 2'b00, 25'h0000AA, 17'd0);
    @(posedge clk); #1; req = 2'b01; #3; req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("withdraw_no_busy", busy, 0);

    // Tied erases: alternating grants, strobes at least 3 cycles apart.
    do_reset();
    set_fields(0, 2'b00, 25'h00000A0, 17'd0);
    set_fields(1, 2'b00, 25'h1F000B0, 17'd7);
    model_last = 1'b1;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = ~model_last;
      model_last = w;
      m = w ? 2'b10 : 2'b01;
      a = w ? 25'h1F000B0 : 25'h00000A0;
      l = w ? 17'd7 : 17'd0;
      exp_q.push_back(ev(m, 2'b00, 2'b00, 3'b100, w, a, l));
      wait_ack(int'(w), ok);
      check("tie_ack_seen", ok, 1);
      check("grant_order", grant_id, w);
      req = req & ~m;
      @(posedge clk);
      #1;
      exp_q.push_back(ev(2'b00, m, 2'b00, 3'b000, w, a, l));
      pulse_engine(2'b00);
      req = (k < 3) ? (req | m) : 2'b00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("erase_gap_min_ge3", strobe_gap_min >= 3, 1);

    // Rejections and the program-length boundary.
    do_reset();
    run_cmd(0, 2'b01, 25'h0000200, 17'd1024, 0);
    run_cmd(1, 2'b10, 25'h0000300, 17'd0, 0);
    run_cmd(0, 2'b11, 25'h0000400, 17'd5, 0);
    run_cmd(1, 2'b01, 25'h0000500, 17'd1023, 4);
    run_cmd(0, 2'b10, 25'h0000600, 17'd131071, 2);

    // Timeout with a non-matching done injected during WAIT.
    do_reset();
    set_fields(0, 2'b00, 25'h0000123, 17'd0);
    exp_q.push_back(ev(2'b01, 2'b00, 2'b00, 3'b100, 1'b0, 25'h0000123, 17'd0));
    req = 2'b01;
    wait_ack(0, ok);
    req = 2'b00;
    check("to_ack_seen", ok, 1);
    exp_q.push_back(ev(2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 25'h0000123, 17'd0));
    err_cyc = -1;
    repeat (10) @(posedge clk);
    #1;
    pulse_engine(2'b01);
    check("prog_done_ignored", busy, 1);
    check("state_wait", dbg_state, ST_WAIT);
    ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (err != 2'b00) ok = 1'b1;
    end
    check("timeout_err_seen", ok, 1);
    @(negedge clk);
    #1;
    check("timeout_latency", err_cyc - strobe_cyc, TIMEOUT);
    check("timeout_idle", busy, 0);

    // Asynchronous reset during WAIT, then requester 1 alone.
    do_reset();
    set_fields(0, 2'b01, 25'h0000777, 17'd5);
    exp_q.push_back(ev(2'b01, 2'b00, 2'b00, 3'b010, 1'b0, 25'h0000777, 17'd5));
    req = 2'b01;
    wait_ack(0, ok);
    req = 2'b00;
    check("rst_ack_seen", ok, 1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {ack, done, err, erase_en, prog_en, read_en, busy, grant_id, cmd_addr, cmd_len}, '0);
    check("async_reset_state", dbg_state, ST_IDLE);
    check("queue_empty_at_reset", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cmd(1, 2'b00, 25'h1ABCDE, 17'd0, 3);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_cmd_arbiter.md
FLASH_CMD_ARBITER -- requirements
Module: flash_cmd_arbiter

Interface
REQ-001 Parameters: TIMEOUT, default 50_000_000, max cycles to wait for an engine done; TO_W, default 26, timeout counter width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req  in  2  per-requester command request; bit i = requester i; held high until ack[i].
REQ-005 op  in  4  op[2i+1:2i] = command of requester i: 00 erase, 01 program, 10 read, 11 illegal.
REQ-006 addr  in  50  addr[25i+24:25i] = flash word address of requester i.
REQ-007 len  in  34  len[17i+16:17i] = word count of requester i; program uses 1..1023, read uses 1..131071, erase ignores it.
REQ-008 ack  out  2  one-cycle pulse: command of requester i accepted.
REQ-009 done  out  2  one-cycle pulse: command of requester i completed.
REQ-010 err  out  2  one-cycle pulse: command of requester i rejected or timed out.
REQ-011 erase_en / prog_en / read_en  out  1 each  one-cycle strobes to the flash engine.
REQ-012 cmd_addr  out  25  address driven to the engine erase, program and read address inputs.
REQ-013 cmd_len  out  17  length to the engine; program length = cmd_len[9:0].
REQ-014 erase_done / prog_done / read_done  in  1 each  engine completion pulses.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 grant_id  out  1  index of the current owner; valid while busy.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-018 In IDLE with any req bit high, the FSM SHALL pick a winner round-robin: if both bits are high, the winner is the requester not granted last.
REQ-019 The last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 On the edge after the pick, the block SHALL assert ack[winner], latch the winner's op/addr/len into cmd_addr/cmd_len, and set grant_id.
REQ-021 In that same cycle the block SHALL pulse exactly one engine strobe and enter WAIT, so strobe latency = 1 clock from the sampled req.
REQ-022 Rejection SHALL occur on op=11, on len=0 for program or read, or on program len>1023.
REQ-023 On rejection the block SHALL pulse ack and err together, assert no strobe, return to IDLE, and still advance the pointer.
REQ-024 In WAIT, only the done matching the latched op SHALL be honoured; non-matching dones are ignored.
REQ-025 A matching done SHALL move the FSM to DONE, where done[grant_id] pulses for one cycle, then the FSM returns to IDLE.
REQ-026 The WAIT counter SHALL clear on strobe and count each WAIT cycle.
REQ-027 When the counter reaches TIMEOUT-1 with no matching done, the block SHALL pulse err[grant_id] and return to IDLE; a done in the same cycle wins over the timeout.
REQ-028 cmd_addr, cmd_len and grant_id SHALL stay stable from strobe until the return to IDLE; req/op changes while busy are ignored.
REQ-029 A req dropped before ack is a withdrawal and SHALL produce no outputs.
REQ-030 Back-to-back commands SHALL start no earlier than the cycle after the return to IDLE, giving a minimum of 3 cycles between strobes.

Reset
REQ-031 On rst: state=IDLE; ack, done, err, strobes and busy = 0; cmd_addr=0, cmd_len=0, grant_id=0; counter=0; pointer=1.
REQ-032 Reset mid-command SHALL abandon the command with no done or err pulse; engine recovery is the engine's own reset.

Structure
REQ-033 Op encodings, the state enum and length limits (1023, 131071) SHALL live in shared package flash_arb_pkg.
REQ-034 One sub-module, flash_rr_pick (2-way round-robin picker with pointer), is natural; everything else is flat.

Verification
REQ-035 Reset, then req=01, op0=10, addr0=0x000100, len0=256, read_done 20 cycles later -> ack=01 and read_en in the same cycle, cmd_addr=0x000100, done=01 one cycle after read_done.
REQ-036 req=11 held, both ops erase, repeated 4 times -> grant order 0,1,0,1; erase_en pulses ≥3 cycles apart.
REQ-037 op0=01, len0=1024 -> ack[0] and err[0] in the same cycle, no prog_en, busy back to 0 the next cycle.
REQ-038 TIMEOUT=100, erase with no erase_done -> err[0] exactly 100 cycles after erase_en; a prog_done injected during WAIT is ignored.
REQ-039 rst asserted during WAIT -> all outputs 0 asynchronously; after release, req=10 is served with grant_id=1.
